// File: rtl/param_lifo_stack.sv
// LIFO stack on a circular buffer: top pointer plus entry count, registered pop
// result with valid strobe, live top peek, sticky error flags and optional overwrite-oldest mode.
module param_lifo_stack #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter bit          WRAP_MODE = 1'b0,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    input  logic              err_clr,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [DATA_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              wrapped
);

    localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              overflow_q, underflow_q, wrapped_q;
    logic              set_ovf, set_udf, set_wrap;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;

    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  ptr_inc;
    logic              is_empty, is_full;
    logic [DATA_W-1:0] top_val;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);
    assign top_idx  = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_W'(1);
    assign ptr_inc  = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
    assign top_val  = mem[top_idx];

    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        set_ovf     = 1'b0;
        set_udf     = 1'b0;
        set_wrap    = 1'b0;

        case ({push, pop})
            2'b10: begin
                if (!is_full) begin
                    mem_we  = 1'b1;
                    ptr_d   = ptr_inc;
                    count_d = count_q + CNT_W'(1);
                end else if (WRAP_MODE) begin
                    // When full, ptr sits on the oldest entry, so writing there drops it.
                    mem_we   = 1'b1;
                    ptr_d    = ptr_inc;
                    set_wrap = 1'b1;
                end else begin
                    set_ovf = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    pop_data_d  = top_val;
                    pop_valid_d = 1'b1;
                    ptr_d       = top_idx;
                    count_d     = count_q - CNT_W'(1);
                end else begin
                    set_udf = 1'b1;
                end
            end
            2'b11: begin
                pop_valid_d = 1'b1;
                if (!is_empty) begin
                    // Replace the top in place: depth and pointer do not move.
                    pop_data_d = top_val;
                    mem_we     = 1'b1;
                    mem_waddr  = top_idx;
                end else begin
                    pop_data_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= (overflow_q & ~err_clr) | set_ovf;
            underflow_q <= (underflow_q & ~err_clr) | set_udf;
            wrapped_q   <= (wrapped_q & ~err_clr) | set_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= din;
        end
    end

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign top       = is_empty ? '0 : top_val;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed bench: one reject-mode and one wrap-mode stack (DEPTH=4) driven with identical stimulus.
module tb_param_lifo_stack;

    logic        clk = 1'b0;
    logic        rst, push, pop, err_clr;
    logic [31:0] din;

    logic [31:0] pd0, top0, pd1, top1;
    logic [2:0]  cnt0, cnt1;
    logic        pv0, emp0, ful0, ovf0, udf0, wrp0;
    logic        pv1, emp1, ful1, ovf1, udf1, wrp1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_lifo_stack #(.DATA_W(32), .DEPTH(4), .WRAP_MODE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
        .pop_data(pd0), .pop_valid(pv0), .top(top0), .count(cnt0), .empty(emp0),
        .full(ful0), .overflow(ovf0), .underflow(udf0), .wrapped(wrp0)
    );

    param_lifo_stack #(.DATA_W(32), .DEPTH(4), .WRAP_MODE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
        .pop_data(pd1), .pop_valid(pv1), .top(top1), .count(cnt1), .empty(emp1),
        .full(ful1), .overflow(ovf1), .underflow(udf1), .wrapped(wrp1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic p, input logic po, input logic [31:0] d, input logic clr);
        push    = p;
        pop     = po;
        din     = d;
        err_clr = clr;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic [2:0] f0, input logic [2:0] f1);
        check({tag, "_flags0"}, {29'd0, ovf0, udf0, wrp0}, {29'd0, f0});
        check({tag, "_flags1"}, {29'd0, ovf1, udf1, wrp1}, {29'd0, f1});
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_count0", 32'(cnt0), 32'd0);
        check("rst_count1", 32'(cnt1), 32'd0);
        check("rst_empty0", 32'(emp0), 32'd1);
        check("rst_pv0", 32'(pv0), 32'd0);
        check("rst_pd0", pd0, 32'd0);
        check("rst_top0", top0, 32'd0);
        check_flags("rst", 3'b000, 3'b000);
        rst = 1'b0;

        // Fill to full
        step(1, 0, 32'd4, 0);
        check("push4_top0", top0, 32'd4);
        check("push4_count0", 32'(cnt0), 32'd1);
        step(1, 0, 32'd5, 0);
        step(1, 0, 32'd6, 0);
        step(1, 0, 32'd7, 0);
        check("full_count0", 32'(cnt0), 32'd4);
        check("full_full0", 32'(ful0), 32'd1);
        check("full_top0", top0, 32'd7);
        check("full_top1", top1, 32'd7);
        check_flags("full", 3'b000, 3'b000);

        // Push while full: reject vs overwrite oldest
        step(1, 0, 32'd8, 0);
        check("ovf_top0", top0, 32'd7);
        check("ovf_count0", 32'(cnt0), 32'd4);
        check("wrap_top1", top1, 32'd8);
        check("wrap_count1", 32'(cnt1), 32'd4);
        check_flags("push_full", 3'b100, 3'b001);

        step(0, 1, 32'd0, 0);
        check("pop1_pd0", pd0, 32'd7);
        check("pop1_pv0", 32'(pv0), 32'd1);
        check("pop1_pd1", pd1, 32'd8);
        check("pop1_full0", 32'(ful0), 32'd0);
        step(0, 1, 32'd0, 0);
        check("pop2_pd0", pd0, 32'd6);
        check("pop2_pd1", pd1, 32'd7);
        step(0, 1, 32'd0, 0);
        check("pop3_pd0", pd0, 32'd5);
        check("pop3_pd1", pd1, 32'd6);
        step(0, 1, 32'd0, 0);
        check("pop4_pd0", pd0, 32'd4);
        check("pop4_pv0", 32'(pv0), 32'd1);
        check("pop4_pd1", pd1, 32'd5);
        check("pop4_pv1", 32'(pv1), 32'd1);
        check("pop4_empty0", 32'(emp0), 32'd1);
        check("pop4_empty1", 32'(emp1), 32'd1);
        check("pop4_top1", top1, 32'd0);

        // Idle: strobe drops, data holds
        step(0, 0, 32'd0, 0);
        check("idle_pv0", 32'(pv0), 32'd0);
        check("idle_pd0", pd0, 32'd4);
        check("idle_pd1", pd1, 32'd5);

        step(0, 0, 32'd0, 1);
        check_flags("clr1", 3'b000, 3'b000);

        // Simultaneous push+pop on non-empty stack
        step(1, 0, 32'd1, 0);
        step(1, 0, 32'd2, 0);
        step(1, 1, 32'd9, 0);
        check("pp_pd0", pd0, 32'd2);
        check("pp_pv0", 32'(pv0), 32'd1);
        check("pp_top0", top0, 32'd9);
        check("pp_count0", 32'(cnt0), 32'd2);
        check("pp_pd1", pd1, 32'd2);
        check_flags("pp", 3'b000, 3'b000);
        step(0, 1, 32'd0, 0);
        check("pp_pop_a0", pd0, 32'd9);
        step(0, 1, 32'd0, 0);
        check("pp_pop_b0", pd0, 32'd1);
        check("pp_pop_b1", pd1, 32'd1);

        // Underflow and bypass on empty stack
        step(0, 1, 32'd0, 0);
        check("udf_pv0", 32'(pv0), 32'd0);
        check("udf_pd0", pd0, 32'd1);
        check_flags("udf", 3'b010, 3'b010);
        step(1, 1, 32'd3, 0);
        check("byp_pd0", pd0, 32'd3);
        check("byp_pv0", 32'(pv0), 32'd1);
        check("byp_count0", 32'(cnt0), 32'd0);
        check("byp_pd1", pd1, 32'd3);
        check_flags("byp", 3'b010, 3'b010);
        // Set wins over clear in the same cycle
        step(0, 1, 32'd0, 1);
        check_flags("setpri", 3'b010, 3'b010);
        step(0, 0, 32'd0, 1);
        check_flags("clr2", 3'b000, 3'b000);

        // Reset mid-sequence with push asserted
        step(0, 1, 32'd0, 0);
        step(1, 0, 32'd1, 0);
        step(1, 0, 32'd2, 0);
        step(1, 0, 32'd3, 0);
        check("pre_rst_count0", 32'(cnt0), 32'd3);
        rst = 1'b1;
        step(1, 0, 32'd4, 0);
        rst = 1'b0;
        check("mrst_count0", 32'(cnt0), 32'd0);
        check("mrst_count1", 32'(cnt1), 32'd0);
        check("mrst_empty0", 32'(emp0), 32'd1);
        check("mrst_pv0", 32'(pv0), 32'd0);
        check("mrst_top0", top0, 32'd0);
        check_flags("mrst", 3'b000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
